// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port round-robin RAM arbiter.
package ram_arb_pkg;

    typedef enum logic {StInit, StRun} state_e;

    localparam int unsigned P0 = 0;
    localparam int unsigned P1 = 1;

    function automatic int unsigned depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Client-side access port of the RAM arbiter: request/grant handshake and read return.
interface ram_arbiter_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin picker: on a tie the port that was not granted last wins.
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (rr_last_i == 1'(P1)) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between two clients with round-robin arbitration,
// after an optional post-reset sweep that writes INIT_VAL to every location.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 6,
    parameter bit                INIT_EN  = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_if.slave      p0_io,
    ram_arbiter_if.slave      p1_io,
    output logic              init_done_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_q_i
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(depth(ADDR_W) - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              rr_last_q, rr_last_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              init_done_q, init_done_d;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [1:0]        req, rr_gnt, gnt;

    assign req = {p1_io.req, p0_io.req};

    ram_arb_rr2 u_rr (
        .req_i     (req),
        .rr_last_i (rr_last_q),
        .gnt_o     (rr_gnt)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        rr_last_d   = rr_last_q;
        gnt         = 2'b00;
        ram_we_o    = 1'b0;
        ram_addr_o  = addr_hold_q;
        ram_data_o  = '0;
        unique case (state_q)
            StInit: begin
                ram_we_o   = 1'b1;
                ram_addr_o = init_cnt_q;
                ram_data_o = INIT_VAL;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LastAddr) begin
                    state_d     = StRun;
                    init_done_d = 1'b1;
                end
            end
            StRun: begin
                gnt = rr_gnt;
                if (gnt[P0]) begin
                    ram_we_o   = p0_io.we;
                    ram_addr_o = p0_io.addr;
                    ram_data_o = p0_io.wdata;
                    rr_last_d  = 1'(P0);
                end else if (gnt[P1]) begin
                    ram_we_o   = p1_io.we;
                    ram_addr_o = p1_io.addr;
                    ram_data_o = p1_io.wdata;
                    rr_last_d  = 1'(P1);
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Only granted reads produce a return beat, one cycle later.
    assign rvalid_d = gnt & ~{p1_io.we, p0_io.we};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT_EN ? StInit : StRun;
            init_cnt_q  <= '0;
            init_done_q <= !INIT_EN;
            rr_last_q   <= 1'(P1);
            rvalid_q    <= 2'b00;
            addr_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            rr_last_q   <= rr_last_d;
            rvalid_q    <= rvalid_d;
            addr_hold_q <= ram_addr_o;
        end
    end

    assign p0_io.gnt    = gnt[P0];
    assign p1_io.gnt    = gnt[P1];
    assign p0_io.rvalid = rvalid_q[P0];
    assign p1_io.rvalid = rvalid_q[P1];
    assign p0_io.rdata  = ram_q_i;
    assign p1_io.rdata  = ram_q_i;
    assign init_done_o  = init_done_q;

endmodule
